// File: rtl/bus_xfer_pkg.sv
// bus_xfer_pkg: opcode and state encodings shared by the bus transfer controller.
package bus_xfer_pkg;
  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LD   = 2'b01;
  localparam logic [1:0] OP_ST   = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// onehot_dec: register index plus enable to a one-hot enable vector.
module onehot_dec #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic [AW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  oh
);
  always_comb
    for (int i = 0; i < N; i++) oh[i] = en && idx == AW'(i);
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences register input/output enables on a shared tristate bus
// in DRIVE->LATCH legs so that at most one source drives the bus at a time.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int W    = 4,
  parameter int TMP  = 3
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [AW-1:0]   req_a,
  input  logic [AW-1:0]   req_b,
  output logic [NREG-1:0] inen,
  output logic [NREG-1:0] oen,
  output logic            ext_oe,
  input  logic [W-1:0]    bus_in,
  output logic [W-1:0]    rd_data,
  output logic            rd_valid,
  output logic            done,
  output logic            err
);
  localparam logic [AW-1:0] TIDX = AW'(TMP);
  logic [1:0] st, ns, op, nop, stp, nstp;
  logic [AW-1:0] a, b, na, nb, src, dst;
  logic acc, bad, fin, src_en, dst_en, ext_d;
  logic [NREG-1:0] oen_d, inen_d;
  assign req_ready = st == S_IDLE;
  assign acc = req_valid && req_ready;
  // only operands the opcode actually uses are range-checked
  assign bad = (req_op != OP_LD && 32'(req_a) >= NREG)
            || (req_op != OP_ST && 32'(req_b) >= NREG)
            || (req_op == OP_SWAP && (req_a == req_b || req_a == TIDX || req_b == TIDX));
  assign fin = st == S_LATCH && !(op == OP_SWAP && stp != 2'd2);
  always_comb begin
    ns = st == S_IDLE ? (acc && !bad ? S_DRIVE : S_IDLE)
       : st == S_DRIVE ? S_LATCH
       : fin ? S_IDLE : S_DRIVE;
    nstp = st == S_IDLE ? 2'd0 : (st == S_LATCH && !fin) ? stp + 2'd1 : stp;
    nop = acc ? req_op : op;
    na = acc ? req_a : a;
    nb = acc ? req_b : b;
    src = nop != OP_SWAP ? na : nstp == 2'd0 ? na : nstp == 2'd1 ? nb : TIDX;
    dst = nop != OP_SWAP ? nb : nstp == 2'd0 ? TIDX : nstp == 2'd1 ? na : nb;
    src_en = ns != S_IDLE && nop != OP_LD;
    ext_d = ns != S_IDLE && nop == OP_LD;
    dst_en = ns == S_LATCH && nop != OP_ST;
  end
  onehot_dec #(.N(NREG), .AW(AW)) u_oen (.idx(src), .en(src_en), .oh(oen_d));
  onehot_dec #(.N(NREG), .AW(AW)) u_inen (.idx(dst), .en(dst_en), .oh(inen_d));
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      st <= S_IDLE;
      stp <= '0;
      op <= OP_MOV;
      a <= '0;
      b <= '0;
      oen <= '0;
      inen <= '0;
      ext_oe <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      st <= ns;
      stp <= nstp;
      op <= nop;
      a <= na;
      b <= nb;
      oen <= oen_d;
      inen <= inen_d;
      ext_oe <= ext_d;
      done <= fin;
      rd_valid <= fin && op == OP_ST;
      err <= acc && bad;
      if (st == S_LATCH && op == OP_ST) rd_data <= bus_in;
    end
endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Sequencer for a bank of NREG 4-bit registers sharing one tristate data bus. Each register has an input-enable and an output-enable. The controller accepts transfer commands over a valid/ready handshake and drives those enables in a fixed DRIVE→LATCH pattern, so at most one source ever drives the bus. It sits between the command source (test host or microsequencer) and the register bank / bus top level.

## Interface
Parameters:
- NREG, 4: number of registers on the bus.
- AW, 2: register index width; NREG ≤ 2**AW.
- W, 4: bus data width.
- TMP, 3: scratch register index used by SWAP.

Ports (one clock `clk`; reset `clr` is asynchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  asynchronous active-high reset.
- req_valid  in  1  command present.
- req_ready  out  1  controller can accept a command; equals (state==IDLE).
- req_op  in  2  opcode: 00 MOV, 01 LD, 10 ST, 11 SWAP.
- req_a  in  AW  source register (MOV, ST, SWAP).
- req_b  in  AW  destination register (MOV, LD, SWAP).
- inen  out  NREG  one-hot register input enable.
- oen  out  NREG  one-hot register output enable.
- ext_oe  out  1  the top level drives the external load word onto the bus.
- bus_in  in  W  sampled bus value.
- rd_data  out  W  word captured by ST.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- done  out  1  one-cycle pulse; command complete.
- err  out  1  one-cycle pulse; command rejected.

## Operation
- States: IDLE, DRIVE, LATCH. A 2-bit step counter `stp` (0..2) selects the current SWAP leg.
- Accept: on a rising edge with req_valid & req_ready, register op/a/b, clear stp, and go to DRIVE.
- Reject: an index ≥ NREG, or SWAP with a==b, a==TMP or b==TMP. The controller stays in IDLE, pulses err next cycle, and asserts no enable.
- DRIVE: assert the source enable only (oen[src], or ext_oe for LD). This gives one cycle for the bus to settle.
- LATCH: hold the source enable and assert the destination enable (inen[dst]). For ST no inen is asserted; rd_data <= bus_in at the end of LATCH.
- Leg mapping:
  - MOV: a→b.
  - LD: ext→b.
  - ST: a→capture.
  - SWAP: stp0 a→TMP, stp1 b→a, stp2 TMP→b.
- After LATCH: if SWAP and stp<2, increment stp and return to DRIVE. Otherwise go to IDLE and pulse done (rd_valid too for ST).
- MOV with a==b is legal: two cycles, register reloads itself.
- Invariant: popcount(oen)+ext_oe ≤ 1 in every cycle; popcount(inen) ≤ 1.
- Enables are registered outputs (decoded from the next state), so they are glitch-free.
- req_* are ignored outside IDLE; there is no queueing.

## Timing
- Reset values: state IDLE, req_ready=1, inen=0, oen=0, ext_oe=0, rd_data=0, rd_valid=0, done=0, err=0, stp=0.
- MOV/LD/ST, with acceptance edge at T:
  - Cycle T+1 is DRIVE and T+2 is LATCH. The destination captures on the edge ending T+2.
  - Cycle T+3: done=1 and req_ready=1.
- SWAP: six busy cycles (T+1..T+6), done in T+7.
- Back-to-back: a command presented during the done cycle is accepted on that edge.
- err appears in T+1. req_ready stays 1 throughout a rejection.
- clr mid-command: all enables drop immediately (asynchronously). A partially completed SWAP leaves registers as last latched. There is no done or err pulse.

## Structure
- Package `bus_xfer_pkg`:
  - opcode localparams OP_MOV/OP_LD/OP_ST/OP_SWAP;
  - state encodings S_IDLE/S_DRIVE/S_LATCH.
- Sub-module `onehot_dec` (index, en → NREG one-hot) is instantiated twice, once for oen and once for inen.
- The register bank and tristate bus live in the top level, not in this block.

## Test plan
1. Reset with req_valid=1 → all enables 0 and req_ready=1; nothing accepted while clr=1.
2. With ext word 4'hA, LD b=2 → T+1 ext_oe=1 only; T+2 ext_oe=1 and inen=4'b0100; T+3 done. Then ST a=2 → rd_data=4'hA with rd_valid.
3. r0=5, r1=9, SWAP a=0 b=1 → oen/inen sequence (0→3), (1→0), (3→1); r0=9, r1=5; done at T+7.
4. Illegal commands: SWAP a=1 b=1, SWAP a=3 b=0, and MOV with an index ≥ NREG → err pulse in T+1, no enable asserted, req_ready stays 1.
5. Back-to-back MOV 0→1 then MOV 1→2, the second presented during done → accepted with no idle gap; r2 equals the original r0.
6. clr asserted during SWAP stp1 LATCH → enables 0 in the same cycle, state IDLE, and a fresh MOV after release completes normally. An assertion checks the bus-exclusivity invariant every cycle.
